// File: rtl/request_responder_if.sv
`default_nettype none
// ============================================================================
// request_responder_if : initiator/responder bus for request_responder
// Rev 1.0
// ============================================================================
interface request_responder_if;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [3:0]  byte_en;
  logic [31:0] data_out;
  logic        busy;
  logic        ack;
  logic        error;
  logic [15:0] txn_count;

  modport master (
    output read_enable, write_enable, addr, data_in, byte_en,
    input  data_out, busy, ack, error, txn_count
  );

  modport slave (
    input  read_enable, write_enable, addr, data_in, byte_en,
    output data_out, busy, ack, error, txn_count
  );
endinterface
`default_nettype wire

// File: rtl/request_responder.sv
`default_nettype none
// ============================================================================
// request_responder : word memory answering read/write requests after a
// fixed wait, with byte lanes, range/alignment rejection and a txn counter.
// Rev 1.0
// ============================================================================
module request_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic               clk,
  input  logic               rst,
  request_responder_if.slave bus
);

  localparam int          c_IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [29:0] c_DEPTH   = 30'(DEPTH_WORDS);
  localparam logic [3:0]  c_LAT     = 4'(LATENCY);
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [c_IDX_W-1:0] idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               write_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic [15:0]        txn_count_q;
  logic [31:0]        mem_q [DEPTH_WORDS];

  logic w_req;
  logic w_accept;
  logic w_reject;
  logic w_commit;

  assign w_req    = bus.read_enable | bus.write_enable;
  assign w_accept = (state_q == c_IDLE) && w_req;
  assign w_reject = (bus.addr[1:0] != 2'b00) || (bus.addr[31:2] >= c_DEPTH);
  // Last WAIT cycle: the edge ending it enters DONE and performs the access.
  assign w_commit = (state_q == c_WAIT) && (cnt_q == 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (w_req) begin
          state_d = c_WAIT;
          cnt_d   = c_LAT;
        end
      end
      c_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = c_DONE;
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      txn_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        idx_q   <= bus.addr[c_IDX_W+1:2];
        wdata_q <= bus.data_in;
        be_q    <= bus.byte_en;
        write_q <= bus.write_enable;
        err_q   <= w_reject;
      end
      // Read data exists only for the single DONE cycle of a good read.
      rdata_q <= (w_commit && !write_q && !err_q) ? mem_q[idx_q] : 32'd0;
      if ((state_q == c_DONE) && (txn_count_q != c_CNT_MAX)) begin
        txn_count_q <= txn_count_q + 16'd1;
      end
    end
  end

  // Storage is deliberately outside the reset domain so reset preserves it.
  always_ff @(posedge clk) begin
    if (w_commit && write_q && !err_q && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.busy      = ~rst & (w_accept | (state_q == c_WAIT));
  assign bus.ack       = (state_q == c_DONE);
  assign bus.error     = (state_q == c_DONE) & err_q;
  assign bus.data_out  = rdata_q;
  assign bus.txn_count = txn_count_q;

endmodule
`default_nettype wire

// File: tb/tb_request_responder.sv
`default_nettype none
// ============================================================================
// tb_request_responder : directed checks of request_responder, LATENCY 2 and 1
// Rev 1.0
// ============================================================================
module tb_request_responder;

  localparam int c_BUSY = 0;
  localparam int c_ACK  = 1;
  localparam int c_ERR  = 2;
  localparam int c_DOUT = 3;
  localparam int c_CNT  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  request_responder_if bus2 ();
  request_responder_if bus1 ();

  request_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  request_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt1 = 0;
  int exp_cnt2 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (sel == 1) begin
      bus1.read_enable = rd; bus1.write_enable = wr;
      bus1.addr = a; bus1.data_in = d; bus1.byte_en = be;
    end else begin
      bus2.read_enable = rd; bus2.write_enable = wr;
      bus2.addr = a; bus2.data_in = d; bus2.byte_en = be;
    end
  endtask

  function automatic logic [31:0] obs(input int sel, input int what);
    logic [31:0] r;
    r = 32'd0;
    if (sel == 1) begin
      case (what)
        c_BUSY:  r = {31'd0, bus1.busy};
        c_ACK:   r = {31'd0, bus1.ack};
        c_ERR:   r = {31'd0, bus1.error};
        c_DOUT:  r = bus1.data_out;
        default: r = {16'd0, bus1.txn_count};
      endcase
    end else begin
      case (what)
        c_BUSY:  r = {31'd0, bus2.busy};
        c_ACK:   r = {31'd0, bus2.ack};
        c_ERR:   r = {31'd0, bus2.error};
        c_DOUT:  r = bus2.data_out;
        default: r = {16'd0, bus2.txn_count};
      endcase
    end
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge of the cycle after ack.
  task automatic xact(input int sel, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic hold, input logic exp_err, input logic [31:0] exp_dout);
    int          lat;
    int          ack_cyc;
    int          busy_cyc;
    logic [31:0] dout;
    logic [31:0] err;
    logic [31:0] busy_done;
    lat = (sel == 1) ? 1 : 2;
    set_req(sel, rd, wr, a, d, be);
    #1;
    busy_cyc  = int'(obs(sel, c_BUSY));
    ack_cyc   = -1;
    dout      = 32'd0;
    err       = 32'd0;
    busy_done = 32'd1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (obs(sel, c_ACK) == 32'd1) begin
        ack_cyc   = k;
        dout      = obs(sel, c_DOUT);
        err       = obs(sel, c_ERR);
        busy_done = obs(sel, c_BUSY);
        break;
      end
      busy_cyc += int'(obs(sel, c_BUSY));
    end
    if (!hold || ack_cyc < 0) set_req(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("ack_cycle", ack_cyc, lat + 1);
    chk("busy_cycles", busy_cyc, lat + 1);
    chk("busy_in_done", busy_done, 32'd0);
    chk("error", err, {31'd0, exp_err});
    chk("data_out", dout, exp_dout);
    @(negedge clk);
    if (sel == 1) begin
      if (exp_cnt1 < 65535) exp_cnt1++;
    end else begin
      if (exp_cnt2 < 65535) exp_cnt2++;
    end
    chk("ack_pulse", obs(sel, c_ACK), 32'd0);
    chk("busy_after", obs(sel, c_BUSY), {31'd0, hold});
    chk("txn_count", obs(sel, c_CNT), (sel == 1) ? exp_cnt1 : exp_cnt2);
  endtask

  initial begin
    rst = 1'b1;
    set_req(2, 1'b1, 1'b1, 32'h10, 32'h1, 4'hF);
    set_req(1, 1'b1, 1'b0, 32'h4, 32'h1, 4'hF);
    repeat (2) @(negedge clk);
    chk("rst_busy", obs(2, c_BUSY), 32'd0);
    chk("rst_ack", obs(2, c_ACK), 32'd0);
    chk("rst_error", obs(2, c_ERR), 32'd0);
    chk("rst_data_out", obs(2, c_DOUT), 32'd0);
    chk("rst_txn_count", obs(2, c_CNT), 32'd0);
    chk("rst_busy_l1", obs(1, c_BUSY), 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    rst = 1'b0;

    // Basic write then read, first request right after reset release
    xact(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'd0);
    xact(2, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 1'b0, 32'hDEADBEEF);

    // Byte lanes, then an all-lanes-off write
    xact(2, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'd0);
    xact(2, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 32'd0);
    xact(2, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 1'b0, 1'b0, 32'h11BB33DD);
    xact(2, 1'b0, 1'b1, 32'h20, 32'h00000000, 4'b0000, 1'b0, 1'b0, 32'd0);
    xact(2, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 1'b0, 1'b0, 32'h11BB33DD);

    // Rejections: misaligned read, out-of-range write aliasing word 0
    xact(2, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'd0);
    xact(2, 1'b1, 1'b0, 32'h22, 32'd0, 4'h0, 1'b0, 1'b1, 32'd0);
    xact(2, 1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF, 1'b0, 1'b1, 32'd0);
    xact(2, 1'b1, 1'b0, 32'h0, 32'd0, 4'h0, 1'b0, 1'b0, 32'hCAFEF00D);

    // Reset in the middle of a write
    xact(2, 1'b0, 1'b1, 32'h30, 32'h55AA55AA, 4'hF, 1'b0, 1'b0, 32'd0);
    set_req(2, 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    chk("midop_wait_busy", obs(2, c_BUSY), 32'd1);
    rst = 1'b1;
    #1;
    chk("midop_busy_in_rst", obs(2, c_BUSY), 32'd0);
    set_req(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midop_no_ack", obs(2, c_ACK), 32'd0);
    end
    chk("midop_txn_count", obs(2, c_CNT), 32'd0);
    rst = 1'b0;
    exp_cnt1 = 0;
    exp_cnt2 = 0;
    xact(2, 1'b1, 1'b0, 32'h30, 32'd0, 4'h0, 1'b0, 1'b0, 32'h55AA55AA);

    // Both enables act as a write; then a request held past ack
    xact(2, 1'b1, 1'b1, 32'h40, 32'h0BADCAFE, 4'hF, 1'b0, 1'b0, 32'd0);
    xact(2, 1'b1, 1'b0, 32'h40, 32'd0, 4'h0, 1'b1, 1'b0, 32'h0BADCAFE);
    xact(2, 1'b1, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0, 1'b0, 32'h0BADCAFE);

    // LATENCY=1 instance
    xact(1, 1'b0, 1'b1, 32'h4, 32'h00000077, 4'hF, 1'b0, 1'b0, 32'd0);
    xact(1, 1'b1, 1'b0, 32'h4, 32'd0, 4'h0, 1'b0, 1'b0, 32'h00000077);
    xact(1, 1'b1, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0, 1'b1, 32'd0);

    // Counter saturation from a preloaded value
    force dut1.txn_count_q = 16'hFFFD;
    @(negedge clk);
    release dut1.txn_count_q;
    exp_cnt1 = 65533;
    chk("sat_preload", obs(1, c_CNT), 32'h0000FFFD);
    xact(1, 1'b1, 1'b0, 32'h4, 32'd0, 4'h0, 1'b0, 1'b0, 32'h00000077);
    xact(1, 1'b1, 1'b0, 32'h4, 32'd0, 4'h0, 1'b0, 1'b0, 32'h00000077);
    xact(1, 1'b0, 1'b1, 32'h8, 32'h1, 4'hF, 1'b0, 1'b0, 32'd0);
    chk("sat_hold", obs(1, c_CNT), 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
